// File: rtl/demultiplexor_16bits_1x2_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: default word width,
// default FIFO depth and the encoding of the Selector destination.
package demultiplexor_16bits_1x2_pkg;

    localparam int ANCHO_DEF       = 16;
    localparam int PROFUNDIDAD_DEF = 2;
    localparam int LOG2_PROF       = $clog2(PROFUNDIDAD_DEF);

    localparam logic DESTINO_0 = 1'b0;
    localparam logic DESTINO_1 = 1'b1;

    // Ready toward the source depends only on the selected FIFO's fullness.
    function automatic logic listo_destino(input logic sel,
                                           input logic full0,
                                           input logic full1);
        return (sel == DESTINO_1) ? !full1 : !full0;
    endfunction

endpackage

// File: rtl/demultiplexor_16bits_1x2_if.sv
// Bus bundle between the word source, the demultiplexer and its two consumers.
// master = source/consumer side, slave = the demultiplexer.
interface demultiplexor_16bits_1x2_if
    import demultiplexor_16bits_1x2_pkg::*;
#(
    parameter int ANCHO       = ANCHO_DEF,
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
);
    localparam int OCW = $clog2(PROFUNDIDAD) + 1;

    logic [ANCHO-1:0] Entrada;
    logic             Selector;
    logic             EntradaValida;
    logic             EntradaListo;

    logic [ANCHO-1:0] Salida0;
    logic             Salida0Valida;
    logic             Salida0Listo;
    logic [ANCHO-1:0] Salida1;
    logic             Salida1Valida;
    logic             Salida1Listo;

    logic [OCW-1:0]   Ocupacion0;
    logic [OCW-1:0]   Ocupacion1;

    modport master (
        output Entrada, Selector, EntradaValida, Salida0Listo, Salida1Listo,
        input  EntradaListo, Salida0, Salida0Valida, Salida1, Salida1Valida,
               Ocupacion0, Ocupacion1
    );

    modport slave (
        input  Entrada, Selector, EntradaValida, Salida0Listo, Salida1Listo,
        output EntradaListo, Salida0, Salida0Valida, Salida1, Salida1Valida,
               Ocupacion0, Ocupacion1
    );
endinterface

// File: rtl/demultiplexor_16bits_1x2_fifo_sincrona.sv
// Small synchronous FIFO. Pointers wrap modulo PROFUNDIDAD; occupancy is a
// separate counter one bit wider. Push on full and pop on empty are ignored.
// When empty the output keeps the last word popped.
module fifo_sincrona
    import demultiplexor_16bits_1x2_pkg::*;
#(
    parameter int ANCHO       = ANCHO_DEF,
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [ANCHO-1:0]             dato_i,
    input  logic                         pop_i,
    output logic [ANCHO-1:0]             dato_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(PROFUNDIDAD):0] ocupacion_o
);
    localparam int PW  = $clog2(PROFUNDIDAD);
    localparam int OCW = PW + 1;

    logic [ANCHO-1:0] mem_q [PROFUNDIDAD];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCW-1:0]   cnt_q, cnt_d;
    logic [ANCHO-1:0] last_q, last_d;
    logic             do_push, do_pop;

    assign full_o      = (cnt_q == OCW'(PROFUNDIDAD));
    assign empty_o     = (cnt_q == '0);
    assign ocupacion_o = cnt_q;
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign dato_o      = empty_o ? last_q : mem_q[rd_ptr_q];

    // Next pointers, occupancy and held-output word.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + OCW'(1);
            2'b01:   cnt_d = cnt_q - OCW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control registers; reset wins over any simultaneous push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    // Storage array; cleared on reset so the head reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PROFUNDIDAD; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= dato_i;
        end
    end
endmodule

// File: rtl/demultiplexor_16bits_1x2.sv
// 1-to-2 stream demultiplexer: steers each accepted word into the FIFO chosen
// by Selector. Ready toward the source never looks at consumer ready.
module demultiplexor_16bits_1x2
    import demultiplexor_16bits_1x2_pkg::*;
#(
    parameter int ANCHO       = ANCHO_DEF,
    parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
) (
    input logic                        clk,
    input logic                        reset,
    demultiplexor_16bits_1x2_if.slave  bus
);
    logic full0, full1, empty0, empty1;
    logic push0, push1, pop0, pop1;
    logic listo;

    assign listo            = listo_destino(bus.Selector, full0, full1);
    assign bus.EntradaListo = listo;

    assign push0 = bus.EntradaValida && listo && (bus.Selector == DESTINO_0);
    assign push1 = bus.EntradaValida && listo && (bus.Selector == DESTINO_1);
    assign pop0  = bus.Salida0Listo && !empty0;
    assign pop1  = bus.Salida1Listo && !empty1;

    assign bus.Salida0Valida = !empty0;
    assign bus.Salida1Valida = !empty1;

    fifo_sincrona #(.ANCHO(ANCHO), .PROFUNDIDAD(PROFUNDIDAD)) u_fifo0 (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push0),
        .dato_i      (bus.Entrada),
        .pop_i       (pop0),
        .dato_o      (bus.Salida0),
        .full_o      (full0),
        .empty_o     (empty0),
        .ocupacion_o (bus.Ocupacion0)
    );

    fifo_sincrona #(.ANCHO(ANCHO), .PROFUNDIDAD(PROFUNDIDAD)) u_fifo1 (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push1),
        .dato_i      (bus.Entrada),
        .pop_i       (pop1),
        .dato_o      (bus.Salida1),
        .full_o      (full1),
        .empty_o     (empty1),
        .ocupacion_o (bus.Ocupacion1)
    );
endmodule

// File: tb/tb_demultiplexor_16bits_1x2.sv
// Bench for the 1-to-2 demultiplexer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_demultiplexor_16bits_1x2;
    localparam int ANCHO = 16;
    localparam int PROF  = 2;

    logic clk = 1'b0;
    logic reset;

    demultiplexor_16bits_1x2_if #(.ANCHO(ANCHO), .PROFUNDIDAD(PROF)) bus ();

    demultiplexor_16bits_1x2 #(.ANCHO(ANCHO), .PROFUNDIDAD(PROF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word is accepted when its destination holds fewer than PROF
    // words; each consumer takes the oldest word when it is ready.
    task automatic model_edge();
        bit acc, p0, p1;
        if (reset) begin
            q0.delete();
            q1.delete();
            return;
        end
        acc = bus.EntradaValida && ((bus.Selector ? q1.size() : q0.size()) < PROF);
        p0  = bus.Salida0Listo && (q0.size() > 0);
        p1  = bus.Salida1Listo && (q1.size() > 0);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (bus.Selector) q1.push_back(bus.Entrada);
            else              q0.push_back(bus.Entrada);
        end
    endtask

    task automatic compare();
        chk("valid0", 32'(bus.Salida0Valida), 32'(q0.size() != 0));
        chk("valid1", 32'(bus.Salida1Valida), 32'(q1.size() != 0));
        chk("ocup0",  32'(bus.Ocupacion0), 32'(q0.size()));
        chk("ocup1",  32'(bus.Ocupacion1), 32'(q1.size()));
        if (q0.size() != 0) chk("salida0", 32'(bus.Salida0), 32'(q0[0]));
        if (q1.size() != 0) chk("salida1", 32'(bus.Salida1), 32'(q1[0]));
        chk("listo", 32'(bus.EntradaListo),
            32'(((bus.Selector ? q1.size() : q0.size()) < PROF)));
    endtask

    // One clock: drive inputs after a falling edge, model at the rising
    // edge, compare at the next falling edge.
    task automatic cycle(input bit rst, input bit v, input bit s,
                         input logic [15:0] d, input bit r0, input bit r1);
        reset             = rst;
        bus.EntradaValida = v;
        bus.Selector      = s;
        bus.Entrada       = d;
        bus.Salida0Listo  = r0;
        bus.Salida1Listo  = r1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset = 1'b1;
        bus.EntradaValida = 1'b0;
        bus.Selector      = 1'b0;
        bus.Entrada       = '0;
        bus.Salida0Listo  = 1'b0;
        bus.Salida1Listo  = 1'b0;
        @(negedge clk);
        cycle(1, 0, 0, 16'h0, 0, 0);
        cycle(1, 0, 0, 16'h0, 0, 0);

        // Reset then idle.
        cycle(0, 0, 0, 16'h0, 0, 0);
        chk("rst_valid0", 32'(bus.Salida0Valida), 0);
        chk("rst_valid1", 32'(bus.Salida1Valida), 0);
        chk("rst_ocup0",  32'(bus.Ocupacion0), 0);
        chk("rst_ocup1",  32'(bus.Ocupacion1), 0);
        chk("rst_salida0", 32'(bus.Salida0), 0);
        chk("rst_listo_s0", 32'(bus.EntradaListo), 1);
        bus.Selector = 1'b1;
        #1;
        chk("rst_listo_s1", 32'(bus.EntradaListo), 1);

        // One word per output, consumers ready.
        cycle(0, 1, 0, 16'h1234, 1, 1);
        chk("lat_valid0", 32'(bus.Salida0Valida), 1);
        chk("lat_salida0", 32'(bus.Salida0), 32'h1234);
        cycle(0, 1, 1, 16'hABCD, 1, 1);
        chk("lat_valid1", 32'(bus.Salida1Valida), 1);
        chk("lat_salida1", 32'(bus.Salida1), 32'hABCD);
        chk("lat_drained0", 32'(bus.Salida0Valida), 0);
        cycle(0, 0, 0, 16'h0, 1, 1);

        // Stall consumer 0 and fill its FIFO.
        cycle(0, 1, 0, 16'h0001, 0, 0);
        cycle(0, 1, 0, 16'h0002, 0, 0);
        chk("full_ocup0", 32'(bus.Ocupacion0), 2);
        bus.Entrada = 16'h0003;
        bus.EntradaValida = 1'b1;
        bus.Selector = 1'b0;
        #1;
        chk("full_listo_s0", 32'(bus.EntradaListo), 0);
        bus.Selector = 1'b1;
        #1;
        chk("full_listo_s1", 32'(bus.EntradaListo), 1);
        cycle(0, 1, 1, 16'h0003, 0, 0);
        chk("redir_salida1", 32'(bus.Salida1), 32'h0003);
        chk("redir_ocup0", 32'(bus.Ocupacion0), 2);

        // Full FIFO: push refused while the pop happens, accepted next cycle.
        cycle(0, 1, 0, 16'h0003, 1, 1);
        chk("refuse_ocup0", 32'(bus.Ocupacion0), 1);
        chk("refuse_salida0", 32'(bus.Salida0), 32'h0002);
        cycle(0, 1, 0, 16'h0003, 1, 0);
        chk("accept_ocup0", 32'(bus.Ocupacion0), 1);
        chk("accept_salida0", 32'(bus.Salida0), 32'h0003);
        cycle(0, 0, 0, 16'h0, 1, 0);
        chk("drain_valid0", 32'(bus.Salida0Valida), 0);

        // Reset while both FIFOs hold data and a push is presented.
        cycle(0, 1, 0, 16'h1111, 0, 0);
        cycle(0, 1, 0, 16'h2222, 0, 0);
        cycle(0, 1, 1, 16'h3333, 0, 0);
        cycle(1, 1, 1, 16'hDEAD, 0, 0);
        chk("mid_rst_valid0", 32'(bus.Salida0Valida), 0);
        chk("mid_rst_valid1", 32'(bus.Salida1Valida), 0);
        chk("mid_rst_ocup0",  32'(bus.Ocupacion0), 0);
        chk("mid_rst_ocup1",  32'(bus.Ocupacion1), 0);
        cycle(0, 0, 1, 16'h0, 1, 1);
        chk("mid_rst_gone1", 32'(bus.Salida1Valida), 0);

        // Random traffic checked against the queue model every cycle.
        for (int i = 0; i < 10000; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 16'h0, 1, 1);
        chk("end_empty0", 32'(bus.Salida0Valida), 0);
        chk("end_empty1", 32'(bus.Salida1Valida), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demultiplexor_16bits_1x2.md
Name: demultiplexor_16bits_1x2

Overview:
Registered 1-to-2 stream demultiplexer: the inverse of the 16-bit 2:1 output multiplexer. Routes each 16-bit input word to output 0 or 1 according to Selector, sampled with the word. Each output has its own small FIFO with valid/ready handshakes, so one stalled consumer does not corrupt the other path. Sits between the datapath word source and two independent consumers (e.g. register-file write port and memory write port).

Parameters:
ANCHO, 16, data word width in bits
PROFUNDIDAD, 2, entries per output FIFO (power of 2, >= 2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
Entrada  input  ANCHO  input data word
Selector  input  1  destination for the current word: 0 -> Salida0, 1 -> Salida1
EntradaValida  input  1  Entrada/Selector hold a valid word
EntradaListo  output  1  block can accept the word presented this cycle
Salida0  output  ANCHO  head word of FIFO 0
Salida0Valida  output  1  FIFO 0 non-empty
Salida0Listo  input  1  consumer 0 takes the head word
Salida1  output  ANCHO  head word of FIFO 1
Salida1Valida  output  1  FIFO 1 non-empty
Salida1Listo  input  1  consumer 1 takes the head word
Ocupacion0  output  log2(PROFUNDIDAD)+1  entries in FIFO 0
Ocupacion1  output  log2(PROFUNDIDAD)+1  entries in FIFO 1

Behaviour:
- Reset (reset=1 at a clock edge): both FIFOs empty, pointers 0. SalidaNValida=0, OcupacionN=0, SalidaN=0. Reset overrides any simultaneous push or pop. Words in flight mid-operation are discarded.
- EntradaListo = NOT full(FIFO[Selector]), where full means OcupacionN == PROFUNDIDAD. It is combinational from Selector and registered occupancy only. It never depends on SalidaNListo, so there is no ready path from output to input.
- Push: EntradaValida & EntradaListo at an edge writes Entrada into FIFO[Selector]. The other FIFO is untouched.
- Pop: SalidaNValida & SalidaNListo at an edge removes the head of FIFO N.
- Latency: a word pushed at edge k is visible on SalidaN with SalidaNValida=1 after edge k. That is 1 cycle and there is no bypass.
- Simultaneous push and pop on the same FIFO: both happen and occupancy is unchanged. A full FIFO still refuses the push that cycle (conservative: EntradaListo=0).
- Push to FIFO 0 and pop from FIFO 1 in the same cycle are independent.
- Ordering: per-output FIFO order equals input acceptance order. No ordering is guaranteed across outputs.
- Pointers are log2(PROFUNDIDAD) bits and wrap modulo PROFUNDIDAD. Occupancy is tracked by a separate counter, one bit wider, with range 0..PROFUNDIDAD.
- SalidaN is the registered head entry and is stable while SalidaNValida=1 and SalidaNListo=0. When the FIFO is empty, SalidaN holds its last value (don't-care to consumers).
- If EntradaValida=1 and EntradaListo=0, the source must hold Entrada and Selector stable. The block does not latch them.
- EntradaValida=0 means no push, regardless of Selector.
- SalidaNListo while SalidaNValida=0 has no effect: no underflow, occupancy does not go negative.

Decomposition:
- Shared package: ANCHO default, the constant for log2(PROFUNDIDAD), and the destination encoding constants DESTINO_0=1'b0 and DESTINO_1=1'b1.
- One sub-module is natural: fifo_sincrona. It is parameterised by ANCHO and PROFUNDIDAD and has push/pop/full/empty/occupancy ports. It is instantiated twice. The top level holds only the Selector steering and the EntradaListo logic.

Test Plan:
- Reset then idle: all SalidaNValida=0, Ocupacion0=Ocupacion1=0, EntradaListo=1 for both Selector values.
- Push 0x1234 with Selector=0, then 0xABCD with Selector=1, consumers ready -> 0x1234 on Salida0 and 0xABCD on Salida1, each exactly one cycle after its push.
- Salida0Listo=0; push 0x0001, 0x0002, 0x0003 with Selector=0 -> first two accepted, Ocupacion0=2, EntradaListo=0 for the third. Switching Selector=1 in the same stall gives EntradaListo=1 and 0x0003 lands in FIFO 1.
- FIFO 0 full; push with Selector=0 and Salida0Listo=1 in the same cycle -> push refused, pop done, Ocupacion0=1. Next cycle the push is accepted and output order is 0x0001, 0x0002, 0x0003.
- Assert reset while both FIFOs hold data and a push is active -> after the edge all valids=0 and occupancies=0, and the pushed word never appears.
- Random 10k-cycle traffic with random SalidaNListo -> per-output scoreboard matches order and data, with no loss or duplication.
